// File: rtl/ex_mem_pipe_pkg.sv
// Shared constants, default widths and pipeline-mode encoding for the EX/MEM register.
package ex_mem_pipe_pkg;

  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic [4:0]  NOPRegAddr   = 5'b00000;
  localparam logic        WriteDisable = 1'b0;
  localparam logic        Stop         = 1'b1;
  localparam logic        NoStop       = 1'b0;
  localparam logic        RstEnable    = 1'b0;
  localparam logic [7:0]  EXE_NOP_OP   = 8'b0000_0000;

  localparam int unsigned EX_MEM_DATA_W    = 32;
  localparam int unsigned EX_MEM_REGADDR_W = 5;
  localparam int unsigned EX_MEM_ALUOP_W   = 8;
  localparam int unsigned EX_MEM_STALL_W   = 6;
  localparam int unsigned EX_MEM_STAGE_IDX = 3;
  localparam int unsigned EX_MEM_CNT_W     = 2;
  localparam int unsigned EX_MEM_BUB_W     = 8;

  typedef enum logic [1:0] {
    MODE_ADVANCE,
    MODE_BUBBLE,
    MODE_HOLD,
    MODE_FLUSH
  } pipe_mode_e;

endpackage

// File: rtl/ex_mem_pipe_sat_counter.sv
// Saturating up-counter; clr has priority over hold, hold over inc.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic         hold,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (!hold && inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ex_mem_pipe.sv
// Parametrised EX/MEM pipeline register with bubble insertion, multi-cycle
// carry return and saturating bubble counter. Optional flush: EX_MEM_FLUSH_EN.
module ex_mem_pipe
  import ex_mem_pipe_pkg::*;
#(
  parameter int unsigned DATA_W    = EX_MEM_DATA_W,
  parameter int unsigned REGADDR_W = EX_MEM_REGADDR_W,
  parameter int unsigned ALUOP_W   = EX_MEM_ALUOP_W,
  parameter int unsigned STALL_W   = EX_MEM_STALL_W,
  parameter int unsigned STAGE_IDX = EX_MEM_STAGE_IDX,
  parameter int unsigned CNT_W     = EX_MEM_CNT_W,
  parameter int unsigned BUB_W     = EX_MEM_BUB_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [STALL_W-1:0]    stall,
`ifdef EX_MEM_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic                  ex_valid,
  input  logic [DATA_W-1:0]     ex_wdata,
  input  logic [REGADDR_W-1:0]  ex_wd,
  input  logic                  ex_wreg,
  input  logic                  ex_whilo,
  input  logic [DATA_W-1:0]     ex_hi,
  input  logic [DATA_W-1:0]     ex_lo,
  input  logic [ALUOP_W-1:0]    ex_aluop,
  input  logic [DATA_W-1:0]     ex_mem_addr,
  input  logic [DATA_W-1:0]     ex_reg2,
  input  logic [2*DATA_W-1:0]   carry_i,
  input  logic [CNT_W-1:0]      cnt_i,
  output logic                  mem_valid,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [REGADDR_W-1:0]  mem_wd,
  output logic                  mem_wreg,
  output logic                  mem_whilo,
  output logic [DATA_W-1:0]     mem_hi,
  output logic [DATA_W-1:0]     mem_lo,
  output logic [ALUOP_W-1:0]    mem_aluop,
  output logic [DATA_W-1:0]     mem_mem_addr,
  output logic [DATA_W-1:0]     mem_reg2,
  output logic [2*DATA_W-1:0]   carry_o,
  output logic [CNT_W-1:0]      cnt_o,
  output logic [BUB_W-1:0]      bubble_cnt
);

  if (STAGE_IDX + 1 >= STALL_W) begin : g_bad_stage_idx
    $error("ex_mem_pipe: STAGE_IDX+1 must be below STALL_W");
  end

  pipe_mode_e mode;
  logic       unused_stall;

  // Only the owning and downstream stall bits matter here.
  assign unused_stall = ^stall;

  always_comb begin
    mode = MODE_ADVANCE;
`ifdef EX_MEM_FLUSH_EN
    if (flush) begin
      mode = MODE_FLUSH;
    end else
`endif
    if (stall[STAGE_IDX] == Stop) begin
      mode = (stall[STAGE_IDX+1] == Stop) ? MODE_HOLD : MODE_BUBBLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n == RstEnable) begin
      mem_valid    <= 1'b0;
      mem_wdata    <= DATA_W'(ZeroWord);
      mem_wd       <= REGADDR_W'(NOPRegAddr);
      mem_wreg     <= WriteDisable;
      mem_whilo    <= WriteDisable;
      mem_hi       <= DATA_W'(ZeroWord);
      mem_lo       <= DATA_W'(ZeroWord);
      mem_aluop    <= ALUOP_W'(EXE_NOP_OP);
      mem_mem_addr <= DATA_W'(ZeroWord);
      mem_reg2     <= DATA_W'(ZeroWord);
      carry_o      <= '0;
      cnt_o        <= '0;
    end else begin
      case (mode)
        MODE_HOLD: ;
        MODE_FLUSH, MODE_BUBBLE: begin
          mem_valid    <= 1'b0;
          mem_wdata    <= DATA_W'(ZeroWord);
          mem_wd       <= REGADDR_W'(NOPRegAddr);
          mem_wreg     <= WriteDisable;
          mem_whilo    <= WriteDisable;
          mem_hi       <= DATA_W'(ZeroWord);
          mem_lo       <= DATA_W'(ZeroWord);
          mem_aluop    <= ALUOP_W'(EXE_NOP_OP);
          mem_mem_addr <= DATA_W'(ZeroWord);
          mem_reg2     <= DATA_W'(ZeroWord);
          // A flushed multi-cycle op is squashed, so its carry is dropped.
          carry_o      <= (mode == MODE_BUBBLE) ? carry_i : '0;
          cnt_o        <= (mode == MODE_BUBBLE) ? cnt_i : '0;
        end
        default: begin
          mem_valid    <= ex_valid;
          mem_wdata    <= ex_wdata;
          mem_wd       <= ex_wd;
          mem_wreg     <= ex_wreg;
          mem_whilo    <= ex_whilo;
          mem_hi       <= ex_hi;
          mem_lo       <= ex_lo;
          mem_aluop    <= ex_aluop;
          mem_mem_addr <= ex_mem_addr;
          mem_reg2     <= ex_reg2;
          carry_o      <= '0;
          cnt_o        <= '0;
        end
      endcase
    end
  end

  sat_counter #(
    .W (BUB_W)
  ) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   ((mode == MODE_ADVANCE) || (mode == MODE_FLUSH)),
    .inc   (mode == MODE_BUBBLE),
    .hold  (mode == MODE_HOLD),
    .count (bubble_cnt)
  );

endmodule
